// File: rtl/vred_logic_wide.sv
// vred_logic_wide: AND/OR/XOR reduction of wide vector beats via a registered fold tree.
// Optional per-element masking is compiled in when VRED_MASK_EN is defined.
module vred_logic_wide #(
  parameter int REQ_DATA_WIDTH  = 128,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int REQ_ADDR_WIDTH  = 32,
  parameter int OPSEL_WIDTH     = 2,
  parameter int SEW_WIDTH       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_DATA_WIDTH-1:0]  in_vec0,
  input  logic [63:0]                in_scalar,
  input  logic                       in_valid,
  input  logic                       in_start,
  input  logic                       in_end,
  input  logic [OPSEL_WIDTH-1:0]     in_opSel,
  input  logic [SEW_WIDTH-1:0]       in_sew,
  input  logic [REQ_ADDR_WIDTH-1:0]  in_addr,
`ifdef VRED_MASK_EN
  input  logic [REQ_DATA_WIDTH/8-1:0] in_mask,
`endif
  output logic [REQ_ADDR_WIDTH-1:0]  out_addr,
  output logic [RESP_DATA_WIDTH-1:0] out_vec,
  output logic                       out_valid,
  output logic                       busy
);

  localparam int W  = REQ_DATA_WIDTH;
  localparam int NW = $clog2(W / 64);
  localparam int NF = NW + 3;

  typedef struct packed {
    logic                      vld;
    logic                      sop;
    logic                      eop;
    logic [OPSEL_WIDTH-1:0]    op;
    logic [SEW_WIDTH-1:0]      sew;
    logic [REQ_ADDR_WIDTH-1:0] addr;
    logic [63:0]               seed;
    logic [W-1:0]              data;
  } stage_t;

  function automatic logic [W-1:0] op_w(input logic [OPSEL_WIDTH-1:0] op,
                                        input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W-1:0] r;
    unique case (int'(op))
      1:       r = a & b;
      2:       r = a | b;
      3:       r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] op_64(input logic [OPSEL_WIDTH-1:0] op,
                                        input logic [63:0] a,
                                        input logic [63:0] b);
    logic [63:0] r;
    unique case (int'(op))
      1:       r = a & b;
      2:       r = a | b;
      3:       r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] sew_mask(input logic [SEW_WIDTH-1:0] s);
    logic [63:0] m;
    unique case (int'(s))
      0:       m = 64'h0000_0000_0000_00ff;
      1:       m = 64'h0000_0000_0000_ffff;
      2:       m = 64'h0000_0000_ffff_ffff;
      default: m = '1;
    endcase
    return m;
  endfunction

  // Fold the low 2*half bits into the low half bits; upper bits end up zero.
  function automatic logic [W-1:0] fold(input logic [OPSEL_WIDTH-1:0] op,
                                        input logic [W-1:0] d,
                                        input int half);
    logic [W-1:0] lm;
    lm = {W{1'b1}} >> (W - half);
    return op_w(op, (d >> half) & lm, d & lm);
  endfunction

  stage_t st_q [NF+1];
  stage_t st_d [NF+1];
  stage_t f;

  logic [63:0]                acc_q, acc_d;
  logic                       av_q, av_d;
  logic                       ae_q, ae_d;
  logic [SEW_WIDTH-1:0]       asew_q, asew_d;
  logic [REQ_ADDR_WIDTH-1:0]  aaddr_q, aaddr_d;
  logic [RESP_DATA_WIDTH-1:0] ovec_q, ovec_d;
  logic                       ovld_q, ovld_d;
  logic [REQ_ADDR_WIDTH-1:0]  oaddr_q, oaddr_d;

`ifdef VRED_MASK_EN
  localparam int MW = $clog2(W / 8);
  logic [MW-1:0] midx;
`endif

  always_comb begin
    st_d = '{default: '0};
`ifdef VRED_MASK_EN
    midx = '0;
`endif
    if (in_valid) begin
      st_d[0].vld  = 1'b1;
      st_d[0].sop  = in_start;
      st_d[0].eop  = in_end;
      st_d[0].op   = in_opSel;
      st_d[0].sew  = in_sew;
      st_d[0].addr = in_addr;
      st_d[0].seed = in_scalar & sew_mask(in_sew);
      st_d[0].data = in_vec0;
`ifdef VRED_MASK_EN
      for (int j = 0; j < W / 8; j++) begin
        midx = MW'(j) >> in_sew;
        if (!in_mask[midx])
          st_d[0].data[8*j +: 8] = (int'(in_opSel) == 1) ? 8'hff : 8'h00;
      end
`endif
    end

    for (int k = 1; k <= NF; k++) begin
      st_d[k] = st_q[k-1];
      if (k <= NW)
        st_d[k].data = fold(st_q[k-1].op, st_q[k-1].data, W >> k);
      else if (int'(st_q[k-1].sew) < 4 + NW - k)
        st_d[k].data = fold(st_q[k-1].op, st_q[k-1].data, 64 >> (k - NW));
    end

    f       = st_q[NF];
    acc_d   = acc_q;
    av_d    = f.vld;
    ae_d    = f.eop;
    asew_d  = f.sew;
    aaddr_d = f.addr;
    if (f.vld) begin
      if (int'(f.op) == 0)
        acc_d = '0;
      else if (f.sop)
        acc_d = op_64(f.op, f.data[63:0], f.seed);
      else
        acc_d = op_64(f.op, acc_q, f.data[63:0]);
    end

    ovld_d  = av_q & ae_q;
    ovec_d  = ovld_d ? RESP_DATA_WIDTH'(acc_q & sew_mask(asew_q)) : '0;
    oaddr_d = ovld_d ? aaddr_q : oaddr_q;

    busy = av_q;
    for (int k = 0; k <= NF; k++)
      busy = busy | st_q[k].vld;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= '{default: '0};
      acc_q   <= '0;
      av_q    <= 1'b0;
      ae_q    <= 1'b0;
      asew_q  <= '0;
      aaddr_q <= '0;
      ovec_q  <= '0;
      ovld_q  <= 1'b0;
      oaddr_q <= '0;
    end else begin
      st_q    <= st_d;
      acc_q   <= acc_d;
      av_q    <= av_d;
      ae_q    <= ae_d;
      asew_q  <= asew_d;
      aaddr_q <= aaddr_d;
      ovec_q  <= ovec_d;
      ovld_q  <= ovld_d;
      oaddr_q <= oaddr_d;
    end
  end

  assign out_vec   = ovec_q;
  assign out_valid = ovld_q;
  assign out_addr  = oaddr_q;

endmodule

// File: doc/vred_logic_wide.md
Name: vred_logic_wide

Overview:
- Parametrised successor to the vector AND/OR/XOR reduction unit.
- Folds an arbitrary power-of-two-wide vector beat down to one SEW element through a registered fold tree.
- Accumulates across beats, starting from the vs1[0] scalar seed.
- Emits one zero-extended scalar per reduction. Sits in the vALU beside the other reduction units and is fed by the same beat stream (start/end/valid/addr).

Parameters:
- REQ_DATA_WIDTH, 128, beat width in bits; power of two, >=64.
- RESP_DATA_WIDTH, 64, result width.
- REQ_ADDR_WIDTH, 32, destination address width.
- OPSEL_WIDTH, 2, operation select width.
- SEW_WIDTH, 2, element-width code width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_vec0  in  REQ_DATA_WIDTH  vs2 beat data.
- in_scalar  in  64  seed (vs1[0]); only the low SEW bits are used; sampled on start beat.
- in_valid  in  1  beat valid.
- in_start  in  1  first beat of reduction.
- in_end  in  1  last beat of reduction.
- in_opSel  in  OPSEL_WIDTH  01=AND, 10=OR, 11=XOR, 00=reserved.
- in_sew  in  SEW_WIDTH  00=8b, 01=16b, 10=32b, 11=64b.
- in_addr  in  REQ_ADDR_WIDTH  destination address.
- in_mask  in  REQ_DATA_WIDTH/8  per-element active bits; present only with VRED_MASK_EN.
- out_addr  out  REQ_ADDR_WIDTH  address of the end beat.
- out_vec  out  RESP_DATA_WIDTH  result, zero-extended.
- out_valid  out  1  one-cycle result pulse.
- busy  out  1  any pipeline stage holds a valid beat.

Behaviour:
- Reset: all outputs 0, all stage registers and accumulator 0. Reset mid-reduction flushes every stage; no out_valid for the aborted reduction.
- Stage s0 captures data, opSel, sew, start, end, addr and seed ANDed with in_valid. in_valid=0 cycles are bubbles: no accumulator update, no output.
- Wide fold stages: log2(REQ_DATA_WIDTH/64) registered stages. Each halves the width: result = op(upper half, lower half). When REQ_DATA_WIDTH=64 there are zero wide fold stages.
- Element fold stages: three registered stages.
  - 64->32 enabled when sew<11.
  - 32->16 enabled when sew<10.
  - 16->8 enabled when sew<01.
  - A disabled stage passes its data through unchanged.
- N_FOLD = log2(REQ_DATA_WIDTH/64)+3.
- Accumulator stage:
  - Start beat: acc <= op(beat, seed). Start overrides any previous accumulator content.
  - Non-start valid beat: acc <= op(acc, beat).
  - Valid beat with no prior start since reset: continues from acc=0.
- Output stage: on end beat, out_vec <= acc result masked to the end beat's SEW bits, zero-extended; out_valid=1 for one cycle; out_addr <= end-beat addr. Otherwise out_vec=0 and out_valid=0. out_addr holds the last end-beat address.
- Latency: out_valid asserts exactly N_FOLD+3 cycles after the in_end beat is presented (7 for W=128, 6 for W=64).
- Throughput: one beat per cycle, no backpressure.
- start & end on the same beat: single-beat reduction with seed.
- Back-to-back reductions (end then start next cycle) are fully supported, with no cross-contamination.
- opSel/sew travel with each beat; changing them mid-reduction is illegal. The result uses the end beat's sew.
- opSel=00: the beat is treated as a bubble for data (acc forced 0). The end beat still pulses out_valid with out_vec=0.

Optional Feature:
- Macro VRED_MASK_EN.
- Defined:
  - in_mask port exists. Bit i gates element i of the beat at SEW granularity; bits above REQ_DATA_WIDTH/SEW are ignored.
  - At s0, a masked-off element is replaced by the op identity: all-ones for AND, zero for OR/XOR.
  - A fully masked reduction returns the seed.
- Undefined: port absent; all elements are active.

Test Plan:
- W=128, AND, sew=11, single start+end beat, in_vec0={64'hFFFF0000FFFFFFFF,64'hFF00FF00FFFFFFFF}, seed all-ones -> 7 cycles later out_vec=64'hFF000000FFFFFFFF, out_valid for 1 cycle, out_addr=beat addr.
- XOR, sew=00, single beat, bytes 0x01..0x10 in ascending lanes, seed 0x00 -> out_vec=64'h10.
- OR, sew=01, 3 beats with 2-cycle in_valid gaps: beat0 hw0=0x0001, beat1 hw7=0x8000, beat2 hw3=0x0100 (others 0), seed 0x0010 -> single pulse, out_vec=64'h8111, 7 cycles after beat2.
- Two back-to-back single-beat reductions: XOR sew=10 result 0xA5A5A5A5, then AND result 0x0 -> two consecutive out_valid cycles with the correct independent values and addrs.
- rst for 1 cycle after 2 beats of a 3-beat OR -> no out_valid, all outputs 0, busy=0. A fresh single-beat reduction afterwards is correct.
- VRED_MASK_EN, AND, sew=10, elements {0x0F0F0F0F,0x00000000,0xFFFFFFFF,0x0F0F0F0F}, mask=4'b1101, seed all-ones -> out_vec=64'h0F0F0F0F. Mask=4'b0000 -> out_vec=seed.
